// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Scheduler for the single regfile write port. It arbitrates between the
// in-order pipeline writeback and results from the long-latency (mul/div)
// unit. Long results are buffered in a small FIFO. The block tracks busy
// destination registers for long ops in flight and raises the issue-stage
// stall on hazards.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   iss_valid/iss_long/iss_rd          : instruction issuing this cycle
//   chk_rs1/chk_rs2/chk_rd/chk_long    : instruction sitting in issue
//   stall                              : issue must hold
//   pwb_valid/pwb_addr/pwb_data        : pipeline writeback request
//   pipe_hold                          : pipeline writeback not taken
//   lwb_valid/lwb_addr/lwb_data        : long-unit result
//   lwb_ready                          : result FIFO can accept
//   rf_wena/rf_waddr/rf_wdata          : regfile write port
module regfile_wb_sched #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 3,
    parameter int MAX_OUT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic        iss_long,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    input  logic        chk_long,
    output logic        stall,
    input  logic        pwb_valid,
    input  logic [4:0]  pwb_addr,
    input  logic [63:0] pwb_data,
    output logic        pipe_hold,
    input  logic        lwb_valid,
    output logic        lwb_ready,
    input  logic [4:0]  lwb_addr,
    input  logic [63:0] lwb_data,
    output logic        rf_wena,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);
    localparam logic [OW-1:0] MAX_OUT_C  = OW'(MAX_OUT);

    // Result storage has no reset so it can map onto distributed/block RAM.
    logic [4:0]  fifo_addr_mem [DEPTH];
    logic [63:0] fifo_data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [OW-1:0] out_q, out_d;
    logic [31:0]   busy_q, busy_d;

    logic        fifo_empty, fifo_full, push, pop;
    logic        force_pop, pwb_req, pipe_win;
    logic        long_iss;
    logic [4:0]  head_addr;
    logic [63:0] head_data;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        head_addr  = fifo_addr_mem[rd_ptr_q];
        head_data  = fifo_data_mem[rd_ptr_q];

        // Ready comes from the registered count only: a full FIFO never
        // accepts, even if the head drains in the same cycle.
        lwb_ready  = rst & ~fifo_full;
        push       = lwb_valid & lwb_ready;

        // Starvation guard: after MAX_WAIT lost cycles the head takes the port.
        force_pop  = ~fifo_empty & (wait_q == MAX_WAIT_C);
        pwb_req    = pwb_valid & (pwb_addr != 5'd0);
        pipe_win   = pwb_req & ~force_pop;
        pop        = ~fifo_empty & ~pipe_win;
        long_iss   = iss_valid & iss_long;

        rf_wena   = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 64'd0;
        pipe_hold = 1'b0;
        if (rst) begin
            pipe_hold = pwb_req & ~pipe_win;
            if (pipe_win) begin
                rf_wena  = 1'b1;
                rf_waddr = pwb_addr;
                rf_wdata = pwb_data;
            end else if (pop) begin
                // An x0 head is drained without touching the regfile.
                rf_wena  = (head_addr != 5'd0);
                rf_waddr = head_addr;
                rf_wdata = head_data;
            end
        end

        stall = ~rst | busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd]
              | (chk_long & (out_q == MAX_OUT_C));

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        if (fifo_empty || pop)     wait_d = '0;
        else if (wait_q != MAX_WAIT_C) wait_d = wait_q + WW'(1);
        else                       wait_d = wait_q;

        out_d = out_q;
        if (long_iss && !pop)      out_d = out_q + OW'(1);
        else if (!long_iss && pop) out_d = out_q - OW'(1);

        // Clear first so a same-cycle set of the same register wins.
        busy_d = busy_q;
        if (pop && head_addr != 5'd0) busy_d[head_addr] = 1'b0;
        if (long_iss && iss_rd != 5'd0) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            out_q    <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= lwb_addr;
            fifo_data_mem[wr_ptr_q] <= lwb_data;
        end
    end

    // Interface contract checks.
    a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!rst)
        !(iss_valid && stall));
    a_push_le_outstanding: assert property (@(posedge clk) disable iff (!rst)
        push |-> (32'(count_q) < 32'(out_q)));
    a_pwb_not_busy: assert property (@(posedge clk) disable iff (!rst)
        !(pwb_valid && busy_q[pwb_addr]));
endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_long;
    logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic        chk_long, stall;
    logic        pwb_valid;
    logic [4:0]  pwb_addr;
    logic [63:0] pwb_data;
    logic        pipe_hold;
    logic        lwb_valid, lwb_ready;
    logic [4:0]  lwb_addr;
    logic [63:0] lwb_data;
    logic        rf_wena;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    always #5 clk = ~clk;

    regfile_wb_sched #(.DEPTH(2), .MAX_WAIT(3), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .chk_long(chk_long), .stall(stall),
        .pwb_valid(pwb_valid), .pwb_addr(pwb_addr), .pwb_data(pwb_data),
        .pipe_hold(pipe_hold),
        .lwb_valid(lwb_valid), .lwb_ready(lwb_ready),
        .lwb_addr(lwb_addr), .lwb_data(lwb_data),
        .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        pwb_valid;
        logic [4:0]  pwb_addr;
        logic [63:0] pwb_data;
        logic [4:0]  rs1, rs2, rd;
        logic        clong;
        logic        exp_wena;
        logic [4:0]  exp_addr;
        logic [63:0] exp_data;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    vec_t vecs[6];
    wr_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [63:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Sample at negedge; every regfile write is matched against the scoreboard.
    task automatic sample();
        wr_t w;
        @(negedge clk);
        if (rf_wena !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wena=%b addr=%0d data=0x%0h expected no write",
                         rf_wena, rf_waddr, rf_wdata);
            end else begin
                w = exp_q.pop_front();
                if (rf_waddr !== w.a || rf_wdata !== w.d) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                             rf_waddr, rf_wdata, w.a, w.d);
                end
            end
        end
        $display("t=%0t wena=%b waddr=%0d wdata=0x%0h hold=%b stall=%b ready=%b",
                 $time, rf_wena, rf_waddr, rf_wdata, pipe_hold, stall, lwb_ready);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_long = 0; iss_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0; chk_long = 0;
        pwb_valid = 0; pwb_addr = 0; pwb_data = 0;
        lwb_valid = 0; lwb_addr = 0; lwb_data = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        iss_valid = 1; iss_long = 1; iss_rd = rd;
        sample();
        chk("issue_no_stall", stall, 0);
        advance();
    endtask

    initial begin
        // Table applied with busy[7] set, one long op outstanding, FIFO empty.
        vecs[0] = '{1'b1, 5'd5,  64'h5555, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5,  64'h5555, 1'b0};
        vecs[1] = '{1'b1, 5'd0,  64'h99,   5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  64'h0,    1'b1};
        vecs[2] = '{1'b0, 5'd4,  64'h44,   5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0,  64'h0,    1'b1};
        vecs[3] = '{1'b1, 5'd31, '1,       5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd31, '1,       1'b1};
        vecs[4] = '{1'b1, 5'd1,  64'h1,    5'd6, 5'd8, 5'd9, 1'b1, 1'b1, 5'd1,  64'h1,    1'b0};
        vecs[5] = '{1'b0, 5'd0,  64'h0,    5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0,  64'h0,    1'b1};

        // Reset with a pending pipeline write that must be ignored.
        idle();
        rst = 0;
        pwb_valid = 1; pwb_addr = 5; pwb_data = 64'h77;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("reset_wena", rf_wena, 0);
            chk("reset_ready", lwb_ready, 0);
            chk("reset_stall", stall, 1);
            chk("reset_hold", pipe_hold, 0);
            advance();
        end
        rst = 1;
        idle();
        chk_rs1 = 5; chk_rs2 = 7; chk_rd = 31; chk_long = 1;
        sample();
        chk("post_reset_stall", stall, 0);
        chk("post_reset_ready", lwb_ready, 1);
        chk("post_reset_wena", rf_wena, 0);
        advance();

        // RAW on long result, then table-driven pipeline writes.
        issue_long(7);
        idle(); chk_rs1 = 7;
        sample();
        chk("raw_stall", stall, 1);
        advance();
        for (int i = 0; i < 6; i++) begin
            idle();
            pwb_valid = vecs[i].pwb_valid; pwb_addr = vecs[i].pwb_addr;
            pwb_data = vecs[i].pwb_data;
            chk_rs1 = vecs[i].rs1; chk_rs2 = vecs[i].rs2; chk_rd = vecs[i].rd;
            chk_long = vecs[i].clong;
            if (vecs[i].exp_wena) expect_wr(vecs[i].exp_addr, vecs[i].exp_data);
            sample();
            chk($sformatf("vec%0d_wena", i), rf_wena, vecs[i].exp_wena);
            chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_data);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_hold", i), pipe_hold, 0);
            advance();
        end
        idle(); chk_rs1 = 7; lwb_valid = 1; lwb_addr = 7; lwb_data = 64'hDEAD;
        sample();
        chk("push7_ready", lwb_ready, 1);
        chk("no_bypass", rf_wena, 0);
        chk("push7_stall", stall, 1);
        advance();
        idle(); chk_rs1 = 7;
        expect_wr(7, 64'hDEAD);
        sample();
        chk("long7_wena", rf_wena, 1);
        chk("long7_stall_still", stall, 1);
        advance();
        idle(); chk_rs1 = 7;
        sample();
        chk("stall_drop", stall, 0);
        advance();

        // Starvation: pipeline wins 3 cycles, then forced head, then held write.
        issue_long(9);
        for (int k = 0; k < 6; k++) begin
            idle();
            pwb_valid = 1; pwb_addr = 3;
            pwb_data = (k == 5) ? 64'h34 : 64'h30 + 64'(k);
            if (k == 0) begin lwb_valid = 1; lwb_addr = 9; lwb_data = 64'h1234; end
            if (k == 4) expect_wr(9, 64'h1234);
            else        expect_wr(3, pwb_data);
            sample();
            chk($sformatf("force_k%0d_hold", k), pipe_hold, (k == 4));
            chk($sformatf("force_k%0d_waddr", k), rf_waddr, (k == 4) ? 9 : 3);
            advance();
        end

        // FIFO full: third result refused, two results drain in order.
        issue_long(10);
        issue_long(11);
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k < 3) begin
                pwb_valid = 1; pwb_addr = 3; pwb_data = 64'h40 + 64'(k);
                lwb_valid = 1; lwb_addr = 5'(10 + k); lwb_data = 64'hA0 + 64'(k);
                expect_wr(3, pwb_data);
            end
            if (k == 3) expect_wr(10, 64'hA0);
            if (k == 4) expect_wr(11, 64'hA1);
            sample();
            chk($sformatf("full_k%0d_ready", k), lwb_ready, (k < 2 || k > 3));
            chk($sformatf("full_k%0d_wena", k), rf_wena, (k < 5));
            advance();
        end

        // x0 handling: pipeline x0 ignored, long x0 popped and dropped.
        issue_long(0);
        for (int k = 0; k < 2; k++) begin
            idle();
            pwb_valid = 1; pwb_addr = 0; pwb_data = 64'h1;
            if (k == 0) begin lwb_valid = 1; lwb_addr = 0; lwb_data = 64'h55; end
            sample();
            chk($sformatf("x0_k%0d_wena", k), rf_wena, 0);
            chk($sformatf("x0_k%0d_hold", k), pipe_hold, 0);
            advance();
        end

        // Outstanding limit; the x0 pop above must have decremented the count.
        for (int r = 1; r <= 4; r++) begin
            idle(); iss_valid = 1; iss_long = 1; iss_rd = 5'(r); chk_long = 1;
            sample();
            chk($sformatf("issue_rd%0d_stall", r), stall, 0);
            advance();
        end
        idle(); chk_long = 1;
        sample();
        chk("max_out_stall", stall, 1);
        advance();
        idle(); chk_long = 1; lwb_valid = 1; lwb_addr = 1; lwb_data = 64'h111;
        sample();
        chk("max_out_push_stall", stall, 1);
        advance();
        idle(); chk_long = 1;
        expect_wr(1, 64'h111);
        sample();
        chk("pop1_stall", stall, 1);
        chk("pop1_wena", rf_wena, 1);
        advance();
        idle(); chk_long = 1; chk_rs1 = 5; chk_rs2 = 6; chk_rd = 7;
        sample();
        chk("after_pop_stall", stall, 0);
        advance();
        idle(); lwb_valid = 1; lwb_addr = 2; lwb_data = 64'h222;
        sample();
        advance();
        idle(); iss_valid = 1; iss_long = 1; iss_rd = 2; chk_long = 1;
        expect_wr(2, 64'h222);
        sample();
        chk("same_cycle_stall", stall, 0);
        chk("same_cycle_waddr", rf_waddr, 2);
        advance();
        idle(); chk_rs1 = 2;
        sample();
        chk("set_wins", stall, 1);
        advance();
        idle(); chk_long = 1;
        sample();
        chk("out_unchanged", stall, 0);
        advance();
        issue_long(5);
        idle(); chk_long = 1;
        sample();
        chk("out_full_again", stall, 1);
        advance();

        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
